// File: rtl/motion_seq.sv
// Segment scheduler for one step_gen channel: a small segment FIFO feeding an
// IDLE/FETCH/RUN sequencer. Optional macro SEG_COUNT_EN adds a completed-segment counter.
module motion_seq #(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [1:0]               wr_op,
  input  logic [31:0]              wr_value,
  input  logic [31:0]              wr_ticks,
  input  logic                     start,
  input  logic                     abort,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              velocity,
  output logic [31:0]              data_out,
  output logic                     set_position,
  output logic                     busy,
  output logic                     seg_done,
  output logic                     underrun,
  output logic                     overflow,
`ifdef SEG_COUNT_EN
  output logic [15:0]              seg_count,
`endif
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);

  localparam logic [1:0] OP_VEL  = 2'd0;
  localparam logic [1:0] OP_POS  = 2'd1;
  localparam logic [1:0] OP_STOP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] value;
    logic [31:0] ticks;
  } seg_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic          w_tick;

  seg_t          r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]   w_level;
  logic          w_full, w_push, w_pop;
  seg_t          w_head;

  logic [31:0]   r_velocity, w_velocity_nxt;
  logic [31:0]   r_data_out, w_data_out_nxt;
  logic          r_set_position, w_set_position_nxt;
  logic          r_seg_done, w_seg_done_nxt;
  logic          r_underrun, w_underrun_nxt;
  logic          r_overflow;
  logic [31:0]   r_remaining, w_remaining_nxt;
  logic          w_more_after_pop, w_more;

  // Prescaler is free-running; segment timing is never re-phased to it.
  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (reset)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Write side: a write is taken on wr_en when not full, or when full but the
  // head is popped in the same cycle; otherwise it is dropped and flagged.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == LVL_FULL);
  assign w_pop   = (r_state == S_FETCH) && !abort;
  assign w_push  = wr_en && !abort && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr[AW-1:0]] <= '{op: wr_op, value: wr_value, ticks: wr_ticks};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort)                r_overflow <= 1'b0;
    else if (wr_en && w_full && !w_pop) r_overflow <= 1'b1;
  end

  // A same-cycle push lands before the next FETCH, so it counts as "more".
  assign w_more_after_pop = (w_level > LVL_ONE) || w_push;
  assign w_more           = (w_level != '0) || w_push;

  always_comb begin
    w_state_nxt        = r_state;
    w_velocity_nxt     = r_velocity;
    w_data_out_nxt     = r_data_out;
    w_set_position_nxt = 1'b0;
    w_seg_done_nxt     = 1'b0;
    w_underrun_nxt     = r_underrun;
    w_remaining_nxt    = r_remaining;

    case (r_state)
      S_IDLE: begin
        if (start && (w_level != '0)) w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        case (w_head.op)
          OP_VEL: begin
            w_velocity_nxt  = w_head.value;
            w_remaining_nxt = w_head.ticks;
            if (w_head.ticks == 32'd0) begin
              w_seg_done_nxt = 1'b1;
              w_state_nxt    = w_more_after_pop ? S_FETCH : S_IDLE;
            end else begin
              w_state_nxt = S_RUN;
            end
          end
          OP_POS: begin
            w_data_out_nxt     = w_head.value;
            w_set_position_nxt = 1'b1;
            w_velocity_nxt     = 32'd0;
            w_seg_done_nxt     = 1'b1;
            w_state_nxt        = w_more_after_pop ? S_FETCH : S_IDLE;
          end
          OP_STOP: begin
            w_velocity_nxt = 32'd0;
            w_seg_done_nxt = 1'b1;
            w_state_nxt    = S_IDLE;
          end
          default: begin
            w_seg_done_nxt = 1'b1;
            w_state_nxt    = w_more_after_pop ? S_FETCH : S_IDLE;
          end
        endcase
      end

      S_RUN: begin
        if (w_tick) begin
          w_remaining_nxt = r_remaining - 32'd1;
          if (r_remaining == 32'd1) begin
            w_seg_done_nxt = 1'b1;
            if (w_more) begin
              w_state_nxt = S_FETCH;
            end else begin
              w_velocity_nxt = 32'd0;
              w_underrun_nxt = 1'b1;
              w_state_nxt    = S_IDLE;
            end
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    if (abort) begin
      w_state_nxt        = S_IDLE;
      w_velocity_nxt     = 32'd0;
      w_set_position_nxt = 1'b0;
      w_seg_done_nxt     = 1'b0;
      w_underrun_nxt     = 1'b0;
      w_remaining_nxt    = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_velocity     <= 32'd0;
      r_data_out     <= 32'd0;
      r_set_position <= 1'b0;
      r_seg_done     <= 1'b0;
      r_underrun     <= 1'b0;
      r_remaining    <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_velocity     <= w_velocity_nxt;
      r_data_out     <= w_data_out_nxt;
      r_set_position <= w_set_position_nxt;
      r_seg_done     <= w_seg_done_nxt;
      r_underrun     <= w_underrun_nxt;
      r_remaining    <= w_remaining_nxt;
    end
  end

`ifdef SEG_COUNT_EN
  logic [15:0] r_seg_count;

  always_ff @(posedge clk) begin
    if (reset || abort)      r_seg_count <= 16'd0;
    else if (w_seg_done_nxt) r_seg_count <= r_seg_count + 16'd1;
  end

  assign seg_count = r_seg_count;
`endif

  assign full         = w_full;
  assign level        = w_level;
  assign velocity     = r_velocity;
  assign data_out     = r_data_out;
  assign set_position = r_set_position;
  assign busy         = (r_state != S_IDLE);
  assign seg_done     = r_seg_done;
  assign underrun     = r_underrun;
  assign overflow     = r_overflow;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_motion_seq.sv
// Directed bench for motion_seq (DEPTH=8, TICK_DIV=4); seg_done and set_position
// events are checked against expected queues by an independent monitor.
module tb_motion_seq;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_op = 2'd3;
  logic [31:0] wr_value = 32'd0;
  logic [31:0] wr_ticks = 32'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        full;
  logic [3:0]  level;
  logic [31:0] velocity;
  logic [31:0] data_out;
  logic        set_position;
  logic        busy;
  logic        seg_done;
  logic        underrun;
  logic        overflow;
  logic [1:0]  dbg_state;
`ifdef SEG_COUNT_EN
  logic [15:0] seg_count;
`endif

  motion_seq #(.DEPTH(DEPTH), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_op(wr_op), .wr_value(wr_value),
    .wr_ticks(wr_ticks), .start(start), .abort(abort), .full(full), .level(level),
    .velocity(velocity), .data_out(data_out), .set_position(set_position),
    .busy(busy), .seg_done(seg_done), .underrun(underrun), .overflow(overflow),
`ifdef SEG_COUNT_EN
    .seg_count(seg_count),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_seg_count = 0;

  // {velocity after seg_done, underrun after, ticks the segment lasted}
  logic [40:0] exp_q[$];
  logic [31:0] pos_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // tick model and monitor
  logic [1:0] tb_presc   = 2'd0;
  logic       edge_tick  = 1'b0;
  logic       edge_fetch = 1'b0;
  int         seg_ticks  = 0;

  always @(posedge clk) begin
    edge_tick  <= !reset && (tb_presc == 2'd3);
    edge_fetch <= !reset && !abort && (dbg_state == 2'd1);
    tb_presc   <= reset ? 2'd0 : tb_presc + 2'd1;
  end

  always @(negedge clk) begin
    logic [40:0] e;
    logic [31:0] p;
    if (edge_fetch) seg_ticks = 0;
    else if (edge_tick) seg_ticks++;
    if (!reset && seg_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_seg_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("seg_velocity", velocity, e[40:9]);
        check("seg_underrun", underrun, e[8]);
        check("seg_ticks", seg_ticks, e[7:0]);
      end
    end
    if (!reset && set_position) begin
      if (pos_q.size() == 0) begin
        check("unexpected_set_position", 64'd1, 64'd0);
      end else begin
        p = pos_q.pop_front();
        check("set_position_data", data_out, p);
        check("set_position_velocity", velocity, 64'd0);
      end
    end
  end

  // driver tasks
  task automatic push(input logic [1:0] op, input logic [31:0] v, input logic [31:0] t);
    @(negedge clk);
    wr_en = 1'b1; wr_op = op; wr_value = v; wr_ticks = t;
    @(negedge clk);
    wr_en = 1'b0; wr_op = 2'd3;
  endtask

  task automatic expect_seg(input logic [31:0] v, input logic u, input logic [7:0] t);
    exp_q.push_back({v, u, t});
    exp_seg_count++;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    exp_seg_count = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check(name, ok, 1'b1);
  endtask

  task automatic check_count(input string name);
`ifdef SEG_COUNT_EN
    check(name, seg_count, exp_seg_count);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // reset state
    check("rst_velocity", velocity, 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_level", level, 64'd0);
    check("rst_full", full, 64'd0);
    check("rst_busy", busy, 64'd0);
    check("rst_flags", {set_position, seg_done, underrun, overflow}, 64'd0);
    check_count("rst_seg_count");

    // start while empty is ignored
    pulse_start();
    check("empty_start_busy", busy, 64'd0);

    // VEL(+500,3): two-edge latency, 3 ticks, then underrun
    push(2'd0, 32'd500, 32'd3);
    expect_seg(32'd0, 1'b1, 8'd3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("s1_state_fetch", dbg_state, 64'd1);
    check("s1_vel_before", velocity, 64'd0);
    @(posedge clk); #1;
    check("s1_vel_500", velocity, 64'd500);
    check("s1_busy", busy, 64'd1);
    wait_idle("s1_idle", 100);
    check("s1_vel_end", velocity, 64'd0);
    check("s1_underrun", underrun, 64'd1);
    check_count("s1_seg_count");
    pulse_abort();
    check("abort_clears_underrun", underrun, 64'd0);

    // POS, VEL(-200,2), STOP
    push(2'd1, 32'd1234, 32'd0);
    push(2'd0, -32'sd200, 32'd2);
    push(2'd2, 32'd0, 32'd0);
    pos_q.push_back(32'd1234);
    expect_seg(32'd0, 1'b0, 8'd0);
    expect_seg(-32'sd200, 1'b0, 8'd2);
    expect_seg(32'd0, 1'b0, 8'd0);
    pulse_start();
    wait_idle("s2_idle", 100);
    check("s2_vel_end", velocity, 64'd0);
    check("s2_underrun", underrun, 64'd0);
    check("s2_level", level, 64'd0);
    check("s2_data_out", data_out, 64'd1234);
    check_count("s2_seg_count");

    // fill to DEPTH, one extra write dropped
    for (int i = 0; i < DEPTH - 1; i++) begin
      push(2'd3, 32'd0, 32'd0);
      expect_seg(32'd0, 1'b0, 8'd0);
    end
    push(2'd2, 32'd0, 32'd0);
    expect_seg(32'd0, 1'b0, 8'd0);
    check("s3_no_overflow_yet", overflow, 64'd0);
    push(2'd0, 32'd999, 32'd1);
    check("s3_full", full, 64'd1);
    check("s3_level", level, 64'd8);
    check("s3_overflow", overflow, 64'd1);
    pulse_start();
    wait_idle("s3_idle", 100);
    check("s3_level_after", level, 64'd0);
    check("s3_velocity_after", velocity, 64'd0);
    check_count("s3_seg_count");
    pulse_abort();
    check("abort_clears_overflow", overflow, 64'd0);

    // STOP keeps remaining entries; the next start resumes
    push(2'd2, 32'd0, 32'd0);
    push(2'd0, 32'd700, 32'd1);
    expect_seg(32'd0, 1'b0, 8'd0);
    expect_seg(32'd0, 1'b1, 8'd1);
    pulse_start();
    wait_idle("stop_idle", 20);
    check("stop_level_kept", level, 64'd1);
    pulse_start();
    wait_idle("resume_idle", 50);
    check("resume_underrun", underrun, 64'd1);
    pulse_abort();

    // VEL(100,0) then VEL(300,5)
    push(2'd0, 32'd100, 32'd0);
    push(2'd0, 32'd300, 32'd5);
    expect_seg(32'd100, 1'b0, 8'd0);
    expect_seg(32'd0, 1'b1, 8'd5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("s4_vel_100", velocity, 64'd100);
    @(posedge clk); #1;
    check("s4_vel_300", velocity, 64'd300);
    wait_idle("s4_idle", 100);
    check_count("s4_seg_count");
    pulse_abort();

    // abort mid-RUN with 3 queued, concurrent wr_en dropped
    push(2'd0, 32'd50, 32'd10);
    for (int i = 0; i < 3; i++) push(2'd3, 32'd0, 32'd0);
    pulse_start();
    repeat (8) @(negedge clk);
    check("s5_level_queued", level, 64'd3);
    check("s5_vel_50", velocity, 64'd50);
    pulse_start();
    check("s5_start_busy_ignored", dbg_state, 64'd2);
    check("s5_level_unchanged", level, 64'd3);
    @(negedge clk);
    abort = 1'b1; wr_en = 1'b1; wr_op = 2'd0; wr_value = 32'd77; wr_ticks = 32'd1;
    @(posedge clk); #1;
    abort = 1'b0; wr_en = 1'b0; wr_op = 2'd3;
    exp_seg_count = 0;
    check("s5_vel_zero", velocity, 64'd0);
    check("s5_level_zero", level, 64'd0);
    check("s5_busy", busy, 64'd0);
    check("s5_flags", {underrun, overflow}, 64'd0);
    check_count("s5_seg_count");
    pulse_start();
    check("s5_later_start_ignored", busy, 64'd0);

    // reset mid-RUN with simultaneous wr_en and start
    push(2'd0, 32'd80, 32'd5);
    pulse_start();
    repeat (4) @(negedge clk);
    check("s6_running", velocity, 64'd80);
    reset = 1'b1; wr_en = 1'b1; wr_op = 2'd0; wr_value = 32'd5; wr_ticks = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0; wr_op = 2'd3;
    exp_seg_count = 0;
    check("s6_velocity", velocity, 64'd0);
    check("s6_data_out", data_out, 64'd0);
    check("s6_level", level, 64'd0);
    check("s6_busy", busy, 64'd0);
    check("s6_flags", {full, set_position, seg_done, underrun, overflow}, 64'd0);
    check_count("s6_seg_count");
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("s6_stays_idle", busy, 64'd0);

    check("exp_q_drained", exp_q.size(), 64'd0);
    check("pos_q_drained", pos_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_seq.md
Name: motion_seq

Overview:
Segment scheduler that sequences one step_gen channel. Host pushes motion segments (velocity target + duration, position preset, stop) into a small FIFO. The sequencer drives step_gen's velocity, data_in and set_position inputs, timing each segment in prescaled ticks. It sits between the host register interface and step_gen, one instance per axis.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
TICK_DIV, 1000, clk cycles per duration tick (matches step_gen accel update period)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
wr_en  in  1  push segment
wr_op  in  2  0=VEL, 1=POS, 2=STOP, 3=NOP
wr_value  in  32  signed velocity (VEL) or position (POS)
wr_ticks  in  32  unsigned duration in ticks (VEL only)
start  in  1  pulse: begin executing FIFO
abort  in  1  pulse: flush and halt
full  out  1  FIFO full
level  out  log2(DEPTH)+1  FIFO occupancy
velocity  out  32  signed target to step_gen
data_out  out  32  to step_gen data_in
set_position  out  1  one-cycle strobe to step_gen
busy  out  1  state != IDLE
seg_done  out  1  one-cycle pulse per completed segment
underrun  out  1  sticky: FIFO ran dry at end of VEL segment
overflow  out  1  sticky: wr_en while full

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, prescaler 0. Priority: reset > abort > everything else.
- Prescaler: free-running 0..TICK_DIV-1; tick = 1 when count == TICK_DIV-1.
- FIFO: push when wr_en && !full. wr_en while full drops the write and sets overflow. Push and pop in the same cycle are legal, including when full, and leave level unchanged.
- States: IDLE, FETCH, RUN.
- IDLE: outputs hold. start with level>0 moves to FETCH. start while empty is ignored.
- FETCH: pops the head in one cycle and acts on the opcode:
  - VEL: velocity<=value, remaining<=ticks, go to RUN. If ticks==0: seg_done, then FETCH if non-empty, else IDLE (no underrun).
  - POS: data_out<=value, set_position=1 for exactly that cycle, velocity<=0, seg_done, then FETCH if non-empty, else IDLE.
  - STOP: velocity<=0, seg_done, go to IDLE. Remaining entries are kept; the next start resumes.
  - NOP: seg_done, next as for POS.
- Latency: start sampled at edge N gives FETCH after N. Velocity and set_position update at edge N+1.
- RUN: on each tick, remaining decrements. On the tick where remaining==1: seg_done, then FETCH if non-empty. If empty: velocity<=0, underrun<=1, go to IDLE.
- VEL with ticks=T lasts T ticks from RUN entry. The first tick may be partial: the prescaler is not re-phased.
- abort (any state): FIFO flushed, velocity<=0, state IDLE, overflow and underrun cleared. set_position is not asserted. wr_en in the same cycle is dropped and does not set overflow.
- start while busy: ignored.
- Velocity is never ramped here; step_gen applies accel limiting.

Optional Feature:
SEG_COUNT_EN: when defined, adds output seg_count[15:0]. It increments on every seg_done, wraps 0xFFFF->0, and is cleared by reset and abort. When undefined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- TICK_DIV=4. Push VEL(+500,3), start -> velocity=500 two cycles after start. It stays 500 for 3 ticks, then velocity=0, underrun=1, seg_done once.
- Push POS(1234), VEL(-200,2), STOP, start -> one-cycle set_position with data_out=1234. Then velocity=-200 for 2 ticks, then 0, IDLE, underrun=0, 3 seg_done pulses.
- Push DEPTH entries then one more -> full=1, level=DEPTH, overflow=1, extra entry never executed.
- VEL(100,0), VEL(300,5), start -> velocity 100 for one cycle, then 300, seg_done on both.
- Abort mid-RUN with 3 queued -> next cycle velocity=0, level=0, busy=0, underrun/overflow=0. A later start is ignored.
- Reset asserted mid-RUN with simultaneous wr_en and start -> all outputs 0, level=0; seg_count=0 if SEG_COUNT_EN.
